// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline enables, bubble insertion and fetch/decode flush
// for the 10-bit core. It handles load-use hazards, taken branches and data
// memory wait states, and has a sticky timeout error state.
module pipe_hazard_ctrl #(
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] id_rs1,
    input  logic [2:0] id_rs2,
    input  logic       id_use1,
    input  logic       id_use2,
    input  logic [2:0] ex_rd,
    input  logic       ex_is_load,
    input  logic       ex_wb,
    input  logic       branch_taken,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       fd_en,
    output logic       ex_en,
    output logic       ex_bubble,
    output logic       flush_fd,
    output logic [1:0] state,
    output logic       mem_err,
    output logic [7:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MEM_WAIT = 2'b10,
        ERROR    = 2'b11
    } state_t;

    // lu_cnt is loaded with the bubbles still owed after the first one
    localparam logic [3:0] LU_INIT   = 4'(LOAD_LAT - 1);
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [3:0] lu_cnt_q, lu_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] stall_cnt_q;
    logic       hazard;
    logic       freeze;

    // Load-use: execute holds a load whose result decode wants to read
    assign hazard = ex_is_load & ex_wb &
                    ((id_use1 & (id_rs1 == ex_rd)) | (id_use2 & (id_rs2 == ex_rd)));

    // Memory not ready: a fresh request in RUN, or still waiting in MEM_WAIT
    assign freeze = ((state_q == RUN) & mem_req & ~mem_ready) |
                    ((state_q == MEM_WAIT) & ~mem_ready);

    // Next-state logic and pipeline control outputs
    always_comb begin
        pc_en      = 1'b1;
        fd_en      = 1'b1;
        ex_en      = 1'b1;
        ex_bubble  = 1'b0;
        flush_fd   = 1'b0;
        state_d    = state_q;
        lu_cnt_d   = lu_cnt_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            RUN, MEM_WAIT: begin
                if (freeze) begin
                    pc_en = 1'b0;
                    fd_en = 1'b0;
                    ex_en = 1'b0;
                    if (state_q == RUN) begin
                        state_d    = MEM_WAIT;
                        wait_cnt_d = 8'd0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_d = ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end else if (branch_taken) begin
                    // The branch flushes the hazarding decode instruction, so it wins
                    flush_fd  = 1'b1;
                    ex_bubble = 1'b1;
                    state_d   = RUN;
                end else if (hazard) begin
                    pc_en     = 1'b0;
                    fd_en     = 1'b0;
                    ex_bubble = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_d  = LU_STALL;
                        lu_cnt_d = LU_INIT;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            LU_STALL: begin
                // Execute holds a bubble here, so branch and memory inputs are ignored
                pc_en     = 1'b0;
                fd_en     = 1'b0;
                ex_bubble = 1'b1;
                lu_cnt_d  = lu_cnt_q - 4'd1;
                if (lu_cnt_q == 4'd1) begin
                    state_d = RUN;
                end
            end
            default: begin
                pc_en = 1'b0;
                fd_en = 1'b0;
                ex_en = 1'b0;
            end
        endcase
        if (!reset) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            ex_en     = 1'b0;
            ex_bubble = 1'b0;
            flush_fd  = 1'b0;
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            lu_cnt_q   <= 4'd0;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            lu_cnt_q   <= lu_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Saturating count of cycles in which the PC was held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 8'd0;
        end else if (!pc_en && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_q <= stall_cnt_q + 8'd1;
        end
    end

    assign state     = state_q;
    assign mem_err   = (state_q == ERROR);
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic [1:0] st;
        logic       pc;
        logic       fd;
        logic       ex;
        logic       bub;
        logic       fl;
        logic       err;
        logic [7:0] sc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] id_rs1 = 3'd5, id_rs2 = 3'd3, ex_rd = 3'd3;
    logic       id_use1 = 1'b1, id_use2 = 1'b0;
    logic       ex_is_load = 1'b1, ex_wb = 1'b1;
    logic       branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
    logic       pc_en, fd_en, ex_en, ex_bubble, flush_fd, mem_err;
    logic [1:0] state;
    logic [7:0] stall_cnt;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    pipe_hazard_ctrl #(.LOAD_LAT(2), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_wb(ex_wb),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .fd_en(fd_en), .ex_en(ex_en), .ex_bubble(ex_bubble),
        .flush_fd(flush_fd), .state(state), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [1:0] st, input logic pc, input logic fd,
                                input logic ex, input logic bub, input logic fl,
                                input logic err, input int sc);
        exp_t e;
        e.st = st; e.pc = pc; e.fd = fd; e.ex = ex;
        e.bub = bub; e.fl = fl; e.err = err; e.sc = 8'(sc);
        return e;
    endfunction

    // hz: 0 = rs2 matches but unused, 1 = rs2 load-use, 2 = rs1 load-use on r0,
    //     3 = rs2 matches but load does not write a register
    task automatic apply(input string tag, input logic r, input int hz, input logic br,
                         input logic mreq, input logic mrdy, input exp_t e);
        @(posedge clk);
        #1;
        reset = r; branch_taken = br; mem_req = mreq; mem_ready = mrdy;
        id_rs1 = 3'd5; id_rs2 = 3'd3; ex_rd = 3'd3;
        id_use1 = 1'b1; id_use2 = 1'b0; ex_is_load = 1'b1; ex_wb = 1'b1;
        case (hz)
            1: id_use2 = 1'b1;
            2: begin id_rs1 = 3'd0; ex_rd = 3'd0; id_use2 = 1'b1; end
            3: begin id_use2 = 1'b1; ex_wb = 1'b0; end
            default: ;
        endcase
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Monitor: compares every presented cycle against the scoreboard head
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {state, pc_en, fd_en, ex_en, ex_bubble, flush_fd, mem_err, stall_cnt};
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got st=%b pc=%b fd=%b ex=%b bub=%b fl=%b err=%b sc=%0d, expected st=%b pc=%b fd=%b ex=%b bub=%b fl=%b err=%b sc=%0d",
                         t, a.st, a.pc, a.fd, a.ex, a.bub, a.fl, a.err, a.sc,
                         e.st, e.pc, e.fd, e.ex, e.bub, e.fl, e.err, e.sc);
            end
        end
    end

    initial begin
        // Reset held low with a branch pending: everything forced 0
        apply("reset_low",     0, 0, 1, 0, 0, mk(0,0,0,0,0,0,0,0));
        apply("reset_release", 1, 0, 0, 0, 0, mk(0,1,1,1,0,0,0,0));
        // Load-use, LOAD_LAT=2
        apply("lu_hazard",     1, 1, 0, 0, 0, mk(0,0,0,1,1,0,0,0));
        apply("lu_stall_ign",  1, 1, 1, 1, 0, mk(1,0,0,1,1,0,0,1));
        apply("lu_release",    1, 0, 0, 0, 0, mk(0,1,1,1,0,0,0,2));
        apply("use2_off",      1, 0, 0, 0, 0, mk(0,1,1,1,0,0,0,2));
        apply("no_wb",         1, 3, 0, 0, 0, mk(0,1,1,1,0,0,0,2));
        apply("r0_hazard",     1, 2, 0, 0, 0, mk(0,0,0,1,1,0,0,2));
        apply("r0_stall",      1, 0, 0, 0, 0, mk(1,0,0,1,1,0,0,3));
        // Branch with simultaneous hazard
        apply("branch_haz",    1, 1, 1, 0, 0, mk(0,1,1,1,1,1,0,4));
        apply("branch_after",  1, 0, 0, 0, 0, mk(0,1,1,1,0,0,0,4));
        // Memory wait: freeze beats branch, hazard bubble on release
        apply("mw_req_br",     1, 0, 1, 1, 0, mk(0,0,0,0,0,0,0,4));
        apply("mw_wait1",      1, 0, 0, 1, 0, mk(2,0,0,0,0,0,0,5));
        apply("mw_wait2",      1, 0, 0, 1, 0, mk(2,0,0,0,0,0,0,6));
        apply("mw_wait3",      1, 0, 0, 1, 0, mk(2,0,0,0,0,0,0,7));
        apply("mw_rel_haz",    1, 1, 0, 1, 1, mk(2,0,0,1,1,0,0,8));
        apply("mw_lu_stall",   1, 0, 0, 0, 0, mk(1,0,0,1,1,0,0,9));
        apply("mw_run",        1, 0, 0, 0, 0, mk(0,1,1,1,0,0,0,10));
        // Release cycle with branch
        apply("mw2_req",       1, 0, 0, 1, 0, mk(0,0,0,0,0,0,0,10));
        apply("mw2_rel_br",    1, 1, 1, 1, 1, mk(2,1,1,1,1,1,0,11));
        apply("mw2_run",       1, 0, 0, 0, 0, mk(0,1,1,1,0,0,0,11));
        // Reset mid-stall
        apply("rst_mid_haz",   1, 1, 0, 0, 0, mk(0,0,0,1,1,0,0,11));
        apply("rst_mid_low",   0, 1, 0, 0, 0, mk(0,0,0,0,0,0,0,0));
        apply("rst_mid_rel",   1, 0, 0, 0, 0, mk(0,1,1,1,0,0,0,0));
        // mem_ready on the last MEM_WAIT cycle wins
        apply("to_last_req",   1, 0, 0, 1, 0, mk(0,0,0,0,0,0,0,0));
        for (int i = 0; i < 14; i++)
            apply("to_last_wait", 1, 0, 0, 1, 0, mk(2,0,0,0,0,0,0,1 + i));
        apply("to_last_rdy",   1, 0, 0, 1, 1, mk(2,1,1,1,0,0,0,15));
        apply("to_last_run",   1, 0, 0, 0, 0, mk(0,1,1,1,0,0,0,15));
        // Full timeout into ERROR
        apply("to_rst",        0, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0));
        apply("to_idle",       1, 0, 0, 0, 0, mk(0,1,1,1,0,0,0,0));
        apply("to_req",        1, 0, 0, 1, 0, mk(0,0,0,0,0,0,0,0));
        for (int i = 0; i < 15; i++)
            apply("to_wait",   1, 0, 0, 1, 0, mk(2,0,0,0,0,0,0,1 + i));
        apply("to_error",      1, 0, 0, 1, 0, mk(3,0,0,0,0,0,1,16));
        apply("to_late_rdy",   1, 0, 0, 1, 1, mk(3,0,0,0,0,0,1,17));
        // Saturation while frozen in ERROR
        for (int k = 0; k < 300; k++)
            apply("sat", 1, 1, k[0], 1, k[1], mk(3,0,0,0,0,0,1,(18 + k > 255) ? 255 : 18 + k));
        apply("sat_rst",       0, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0));
        apply("sat_rel",       1, 0, 0, 0, 0, mk(0,1,1,1,0,0,0,0));
        // Drain the scoreboard with a bounded wait
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
